coin_acceptor: RTL and testbench

- Front-end of the vending machine: sits between the coin-slot light barrier and the vending state machine.
- Measures how long each coin blocks the barrier and classifies it by that duration.
- Drives the state machine's coin-input interface: a 4-bit coin value plus a one-cycle new_coin strobe.
- Coins that are out of window, arrive while acceptance is disabled, or jam the slot are routed to the return flap via reject.

---
 rtl/vending_pkg.sv | 19 +
 rtl/coin_debounce.sv | 54 +++++
 rtl/coin_acceptor.sv | 159 +++++++++++++++
 tb/tb_coin_acceptor.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// vending_pkg - shared definitions for the vending machine front-end.
//   COIN_1/COIN_2/COIN_4 : coin value codes, also used by the vending state machine
//   acc_state_e          : coin_acceptor FSM states
package vending_pkg;

    localparam logic [3:0] COIN_1 = 4'd1;
    localparam logic [3:0] COIN_2 = 4'd2;
    localparam logic [3:0] COIN_4 = 4'd4;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        CLASSIFY,
        EMIT,
        JAM,
        GAP
    } acc_state_e;

endpackage

// File: rtl/coin_debounce.sv
// coin_debounce - 2-FF synchronizer plus optional debounce filter for the
// coin-slot light barrier.
//   clk, rst_n : clock, asynchronous active-low reset
//   raw        : light barrier, high = blocked, asynchronous to clk
//   level      : filtered sensor level (sense_f)
// Configuration macro: COIN_ACCEPTOR_DEBOUNCE_EN. When defined, the level
// changes only after DEB_CYCLES consecutive differing synchronized samples,
// which delays both edges equally so pulse widths are preserved. When
// undefined, level is the synchronizer output.
module coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);

    logic [1:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b00;
        else        sync <= {sync[0], raw};
    end

`ifdef COIN_ACCEPTOR_DEBOUNCE_EN
    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic [DW-1:0] deb_cnt;
    logic          filt;

    // Any sample agreeing with the current level restarts the run count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            filt    <= 1'b0;
        end else if (sync[1] == filt) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
            filt    <= sync[1];
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign level = filt;
`else
    logic deb_unused;
    assign deb_unused = (DEB_CYCLES > 0);
    assign level      = sync[1];
`endif

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor - measures how long a coin blocks the light barrier and
// classifies it into a coin value for the vending state machine.
//   clk50m     : 50 MHz system clock
//   rst_n      : asynchronous active-low reset
//   coin_sense : raw light barrier (high = blocked), asynchronous
//   accept_en  : coins may be credited (sampled in CLASSIFY only)
//   coin       : value of the last credited coin, held until the next one
//   new_coin   : one-cycle strobe, coin valid
//   reject     : one-cycle pulse opening the return flap
//   busy       : registered, high whenever the FSM is not IDLE
// Configuration macro: COIN_ACCEPTOR_DEBOUNCE_EN (see coin_debounce).
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16,
    parameter int T1_MIN     = 50,
    parameter int T1_MAX     = 99,
    parameter int T2_MIN     = 100,
    parameter int T2_MAX     = 149,
    parameter int T4_MIN     = 150,
    parameter int T4_MAX     = 199,
    parameter int JAM_CYCLES = 1000,
    parameter int GAP_CYCLES = 20
) (
    input  logic       clk50m,
    input  logic       rst_n,
    input  logic       coin_sense,
    input  logic       accept_en,
    output logic [3:0] coin,
    output logic       new_coin,
    output logic       reject,
    output logic       busy
);

    logic             sense_f;
    acc_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [CNT_W-1:0] gap_cnt, gap_nxt;
    logic [3:0]       coin_nxt;
    logic             new_coin_nxt, reject_nxt;
    logic             match;
    logic [3:0]       match_val;

    coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk   (clk50m),
        .rst_n (rst_n),
        .raw   (coin_sense),
        .level (sense_f)
    );

    // Lowest window is tested first so overlaps resolve to the smaller value.
    always_comb begin
        match     = 1'b0;
        match_val = 4'd0;
        if (cnt >= CNT_W'(T1_MIN) && cnt <= CNT_W'(T1_MAX)) begin
            match     = 1'b1;
            match_val = COIN_1;
        end else if (cnt >= CNT_W'(T2_MIN) && cnt <= CNT_W'(T2_MAX)) begin
            match     = 1'b1;
            match_val = COIN_2;
        end else if (cnt >= CNT_W'(T4_MIN) && cnt <= CNT_W'(T4_MAX)) begin
            match     = 1'b1;
            match_val = COIN_4;
        end
    end

    // Saturating increment: the width counter never wraps.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        gap_nxt      = gap_cnt;
        coin_nxt     = coin;
        new_coin_nxt = 1'b0;
        reject_nxt   = 1'b0;
        case (state)
            IDLE: begin
                // GAP guarantees sense_f was clear before IDLE, so a high
                // level here is a fresh rising edge.
                if (sense_f) begin
                    state_nxt = MEASURE;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            MEASURE: begin
                if (!sense_f) begin
                    state_nxt = CLASSIFY;
                end else begin
                    cnt_nxt = cnt_inc;
                    if (cnt_inc >= CNT_W'(JAM_CYCLES)) begin
                        state_nxt  = JAM;
                        reject_nxt = 1'b1;
                    end
                end
            end
            CLASSIFY: begin
                gap_nxt = '0;
                if (match && accept_en) begin
                    // coin and new_coin register together and are seen during EMIT.
                    state_nxt    = EMIT;
                    coin_nxt     = match_val;
                    new_coin_nxt = 1'b1;
                end else begin
                    state_nxt  = GAP;
                    reject_nxt = 1'b1;
                end
            end
            EMIT: begin
                state_nxt = GAP;
                gap_nxt   = '0;
            end
            JAM: begin
                if (!sense_f) begin
                    state_nxt = GAP;
                    gap_nxt   = '0;
                end
            end
            GAP: begin
                // Blockage during the gap restarts the count and is otherwise ignored.
                if (sense_f) begin
                    gap_nxt = '0;
                end else if (gap_cnt >= CNT_W'(GAP_CYCLES - 1)) begin
                    state_nxt = IDLE;
                    gap_nxt   = '0;
                end else begin
                    gap_nxt = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                gap_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk50m or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            gap_cnt  <= '0;
            coin     <= 4'd0;
            new_coin <= 1'b0;
            reject   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            gap_cnt  <= gap_nxt;
            coin     <= coin_nxt;
            new_coin <= new_coin_nxt;
            reject   <= reject_nxt;
            busy     <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor - directed self-checking bench for coin_acceptor.
// Expected coin/reject events are queued when a pulse is driven and are
// checked (kind, value, arrival cycle) by a monitor when the DUT reports them.
module tb_coin_acceptor;
    import vending_pkg::*;

`ifdef COIN_ACCEPTOR_DEBOUNCE_EN
    localparam int LAT = 6;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    logic       clk50m     = 1'b0;
    logic       rst_n      = 1'b0;
    logic       coin_sense = 1'b0;
    logic       accept_en  = 1'b1;
    logic [3:0] coin;
    logic       new_coin;
    logic       reject;
    logic       busy;

    coin_acceptor u_dut (
        .clk50m     (clk50m),
        .rst_n      (rst_n),
        .coin_sense (coin_sense),
        .accept_en  (accept_en),
        .coin       (coin),
        .new_coin   (new_coin),
        .reject     (reject),
        .busy       (busy)
    );

    always #10 clk50m = ~clk50m;

    typedef struct {
        bit         is_rej;
        logic [3:0] val;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    always @(posedge clk50m) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk50m) begin
        if (rst_n && (new_coin === 1'b1 || reject === 1'b1)) begin
            exp_t e;
            bit   have;
            chk("exclusive", {31'b0, new_coin & reject}, 32'd0);
            have = (sb.size() > 0);
            chk("event_expected", {31'b0, have}, 32'd1);
            if (have) begin
                e = sb.pop_front();
                chk("event_kind", {31'b0, reject}, {31'b0, e.is_rej});
                if (!e.is_rej) chk("coin_value", {28'b0, coin}, {28'b0, e.val});
                chk("event_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk50m);
        #1;
    endtask

    task automatic coin_on(output int r);
        @(posedge clk50m);
        #1;
        coin_sense = 1'b1;
        r = cyc;
    endtask

    task automatic coin_off(output int f);
        @(posedge clk50m);
        #1;
        coin_sense = 1'b0;
        f = cyc;
    endtask

    // Raw pulse of exactly w cycles; f is the first clear cycle.
    task automatic pulse(input int w, output int f);
        int r;
        coin_on(r);
        repeat (w - 1) @(posedge clk50m);
        coin_off(f);
    endtask

    initial begin
        int f;
        int r;

        // Reset state
        idle(3);
        chk("rst_coin", {28'b0, coin}, 32'd0);
        chk("rst_new_coin", {31'b0, new_coin}, 32'd0);
        chk("rst_reject", {31'b0, reject}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        rst_n = 1'b1;
        idle(5);

        // 75-cycle coin -> value 1, two cycles after sense_f falls
        pulse(75, f);
        sb.push_back('{1'b0, COIN_1, f + LAT + 2});
        idle(40);
        chk("busy_idle_after_coin", {31'b0, busy}, 32'd0);

        // 120 -> value 2, 180 -> value 4, value held afterwards
        pulse(120, f);
        sb.push_back('{1'b0, COIN_2, f + LAT + 2});
        idle(40);
        pulse(180, f);
        sb.push_back('{1'b0, COIN_4, f + LAT + 2});
        idle(40);
        chk("coin_hold_4", {28'b0, coin}, 32'd4);

        // Out-of-window widths: reject, coin unchanged
        pulse(30, f);
        sb.push_back('{1'b1, 4'd0, f + LAT + 2});
        idle(40);
        pulse(220, f);
        sb.push_back('{1'b1, 4'd0, f + LAT + 2});
        idle(40);
        chk("coin_hold_after_reject", {28'b0, coin}, 32'd4);

        // Acceptance disabled: valid width is rejected
        accept_en = 1'b0;
        pulse(75, f);
        sb.push_back('{1'b1, 4'd0, f + LAT + 2});
        idle(40);
        accept_en = 1'b1;
        chk("coin_hold_disabled", {28'b0, coin}, 32'd4);

        // Jam: reject when the count reaches 1000 while still blocked
        coin_on(r);
        sb.push_back('{1'b1, 4'd0, r + LAT + 1000});
        idle(1500);
        chk("busy_in_jam", {31'b0, busy}, 32'd1);
        coin_off(f);
        idle(10);
        chk("busy_during_gap", {31'b0, busy}, 32'd1);
        idle(30);
        chk("busy_after_gap", {31'b0, busy}, 32'd0);
        pulse(75, f);
        sb.push_back('{1'b0, COIN_1, f + LAT + 2});
        idle(40);

        // Blockage during GAP: no credit, no reject
        pulse(120, f);
        sb.push_back('{1'b0, COIN_2, f + LAT + 2});
        pulse(10, r);
        idle(60);
        chk("busy_after_gap_block", {31'b0, busy}, 32'd0);
        chk("coin_after_gap_block", {28'b0, coin}, 32'd2);

        // Asynchronous reset mid-MEASURE
        coin_on(r);
        idle(30);
        rst_n = 1'b0;
        #1;
        chk("arst_coin", {28'b0, coin}, 32'd0);
        chk("arst_new_coin", {31'b0, new_coin}, 32'd0);
        chk("arst_reject", {31'b0, reject}, 32'd0);
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_state", {31'b0, u_dut.state === IDLE}, 32'd1);
        coin_sense = 1'b0;
        idle(10);
        rst_n = 1'b1;
        idle(20);
        chk("busy_after_arst", {31'b0, busy}, 32'd0);

        // 2-cycle glitches: filtered with debounce, else measured and rejected
        for (int i = 0; i < 3; i++) begin
            pulse(2, f);
            if (!DEB) sb.push_back('{1'b1, 4'd0, f + LAT + 2});
            idle(40);
        end
        chk("coin_after_glitch", {28'b0, coin}, 32'd0);

        idle(50);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
